// File: rtl/snax_alu_simd_wrapper.sv
// snax_alu_simd_wrapper: NumPE-lane SIMD ALU between two operand streams and one result stream, driven by a CSR job.
// Ports: clk_i/rst_i (async active-high), stream2acc_0/1 operand A/B streams, acc2stream_0 result stream,
//        csr_reg_set_* {mode, length, start} write channel, csr_reg_ro_set_o {busy, last job cycle count}.
module snax_alu_simd_wrapper #(
    parameter int NumPE        = 4,
    parameter int DataWidth    = 64,
    parameter int RegDataWidth = 32,
    parameter int OutDepth     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumPE*DataWidth-1:0]    stream2acc_0_data_i,
    input  logic                          stream2acc_0_valid_i,
    output logic                          stream2acc_0_ready_o,
    input  logic [NumPE*DataWidth-1:0]    stream2acc_1_data_i,
    input  logic                          stream2acc_1_valid_i,
    output logic                          stream2acc_1_ready_o,
    output logic [NumPE*DataWidth-1:0]    acc2stream_0_data_o,
    output logic                          acc2stream_0_valid_o,
    input  logic                          acc2stream_0_ready_i,
    input  logic [RegDataWidth-1:0]       csr_reg_set_i [3],
    input  logic                          csr_reg_set_valid_i,
    output logic                          csr_reg_set_ready_o,
    output logic [RegDataWidth-1:0]       csr_reg_ro_set_o [2]
);
    localparam int LW = NumPE * DataWidth;
    localparam int PW = $clog2(OutDepth);
    localparam int CW = $clog2(OutDepth + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    state_e                  state_q, state_d;
    logic [2:0]              mode_q, mode_d;
    logic [RegDataWidth-1:0] len_q, len_d, rem_q, rem_d, cyc_q, cyc_d;
    logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [LW-1:0]           mem_q [OutDepth];
    logic [LW-1:0]           res;
    logic                    csr_fire, start, fire, pop;
    logic                    unused_csr;

    assign unused_csr = ^{csr_reg_set_i[0][RegDataWidth-1:3], csr_reg_set_i[2][RegDataWidth-1:1]};
    assign pop  = cnt_q != '0 && acc2stream_0_ready_i;
    // A full FIFO may still accept a beat when its head leaves in the same cycle.
    assign fire = state_q == RUN && rem_q != '0 && stream2acc_0_valid_i && stream2acc_1_valid_i
                  && (cnt_q != CW'(OutDepth) || pop);
    assign stream2acc_0_ready_o = fire;
    assign stream2acc_1_ready_o = fire;
    assign csr_reg_set_ready_o  = state_q == IDLE;
    assign csr_fire             = csr_reg_set_valid_i && csr_reg_set_ready_o;
    assign start                = csr_reg_set_i[2][0];
    assign acc2stream_0_valid_o = cnt_q != '0;
    assign acc2stream_0_data_o  = acc2stream_0_valid_o ? mem_q[rptr_q] : '0;
    assign csr_reg_ro_set_o[0]  = {{(RegDataWidth-1){1'b0}}, state_q != IDLE};
    assign csr_reg_ro_set_o[1]  = cyc_q;

    for (genvar g = 0; g < NumPE; g++) begin : g_lane
        logic [DataWidth-1:0] a, b;
        assign a = stream2acc_0_data_i[g*DataWidth +: DataWidth];
        assign b = stream2acc_1_data_i[g*DataWidth +: DataWidth];
        assign res[g*DataWidth +: DataWidth] =
            mode_q == 3'd0 ? a + b :
            mode_q == 3'd1 ? a - b :
            mode_q == 3'd2 ? a * b :
            mode_q == 3'd3 ? a ^ b :
            mode_q == 3'd4 ? ($signed(a) > $signed(b) ? a : b) :
            mode_q == 3'd5 ? ($signed(a) < $signed(b) ? a : b) : a;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        rem_d   = rem_q;
        cyc_d   = (state_q != IDLE && ~&cyc_q) ? cyc_q + 1'b1 : cyc_q;
        if (csr_fire) begin
            mode_d = csr_reg_set_i[0][2:0];
            // A zero-length start only updates the mode; the job never launches.
            if (!start) len_d = csr_reg_set_i[1];
            else if (csr_reg_set_i[1] != '0) begin
                len_d   = csr_reg_set_i[1];
                rem_d   = csr_reg_set_i[1];
                cyc_d   = '0;
                state_d = RUN;
            end
        end
        if (fire) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == RegDataWidth'(1)) state_d = DRAIN;
        end
        if (state_q == DRAIN && cnt_q == '0) state_d = IDLE;
        wptr_d = fire ? (wptr_q == PW'(OutDepth - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d = pop ? (rptr_q == PW'(OutDepth - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
        cnt_d  = cnt_q + CW'(fire) - CW'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            cyc_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            cyc_q   <= cyc_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: the output is masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (fire) mem_q[wptr_q] <= res;
    end
endmodule

// File: tb/tb_snax_alu_simd_wrapper.sv
// tb_snax_alu_simd_wrapper: directed checks of the SIMD ALU wrapper at 64-bit and 8-bit lane widths in lockstep.
module tb_snax_alu_simd_wrapper;
    logic         clk, rst_i;
    logic [255:0] a64, b64, o_d64;
    logic [31:0]  a8, b8, o_d8;
    logic         v0, v1, out_rdy, csr_valid;
    logic [31:0]  csr_set [3];
    logic [31:0]  ro64 [2];
    logic [31:0]  ro8 [2];
    logic         r0_64, r1_64, o_v64, cr64;
    logic         r0_8, r1_8, o_v8, cr8;
    logic [63:0]  a_base, b_base, step;
    logic [255:0] q64 [$];
    logic [31:0]  q8 [$];
    int           n_vec, n_err, fire_cnt, fb, qb64, qb8, lat_bad;
    logic         prev_fire;

    snax_alu_simd_wrapper #(.NumPE(4), .DataWidth(64), .RegDataWidth(32), .OutDepth(4)) u64 (
        .clk_i(clk), .rst_i(rst_i),
        .stream2acc_0_data_i(a64), .stream2acc_0_valid_i(v0), .stream2acc_0_ready_o(r0_64),
        .stream2acc_1_data_i(b64), .stream2acc_1_valid_i(v1), .stream2acc_1_ready_o(r1_64),
        .acc2stream_0_data_o(o_d64), .acc2stream_0_valid_o(o_v64), .acc2stream_0_ready_i(out_rdy),
        .csr_reg_set_i(csr_set), .csr_reg_set_valid_i(csr_valid), .csr_reg_set_ready_o(cr64),
        .csr_reg_ro_set_o(ro64)
    );

    snax_alu_simd_wrapper #(.NumPE(4), .DataWidth(8), .RegDataWidth(32), .OutDepth(4)) u8 (
        .clk_i(clk), .rst_i(rst_i),
        .stream2acc_0_data_i(a8), .stream2acc_0_valid_i(v0), .stream2acc_0_ready_o(r0_8),
        .stream2acc_1_data_i(b8), .stream2acc_1_valid_i(v1), .stream2acc_1_ready_o(r1_8),
        .acc2stream_0_data_o(o_d8), .acc2stream_0_valid_o(o_v8), .acc2stream_0_ready_i(out_rdy),
        .csr_reg_set_i(csr_set), .csr_reg_set_valid_i(csr_valid), .csr_reg_set_ready_o(cr8),
        .csr_reg_ro_set_o(ro8)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_i) prev_fire = 0;
        else begin
            if (prev_fire && !o_v64) lat_bad++;
            if (o_v64 && out_rdy) q64.push_back(o_d64);
            if (o_v8 && out_rdy) q8.push_back(o_d8);
            prev_fire = r0_64;
            if (r0_64) fire_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply();
        logic [63:0] av, bv;
        av  = a_base + step * 64'(fire_cnt - fb);
        bv  = b_base + step * 64'(fire_cnt - fb);
        a64 = {4{av}};
        b64 = {4{bv}};
        a8  = {4{av[7:0]}};
        b8  = {4{bv[7:0]}};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic begin_job(input logic [63:0] a, input logic [63:0] b, input logic [63:0] s);
        fb     = fire_cnt;
        qb64   = q64.size();
        qb8    = q8.size();
        a_base = a;
        b_base = b;
        step   = s;
        apply();
    endtask

    task automatic csr_write(input logic [2:0] m, input int len, input logic st);
        logic hs;
        csr_set[0] = {29'd0, m};
        csr_set[1] = len;
        csr_set[2] = {31'd0, st};
        csr_valid  = 1;
        hs         = 0;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = cr64 && cr8;
            tick();
        end
        csr_valid = 0;
        chk("csr_hs", hs, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (ro64[0][0] || ro8[0][0]); i++) tick();
        chk("idle", {ro64[0][0], ro8[0][0]}, 0);
    endtask

    task automatic check_beats(input string tag, input int n, input logic [63:0] e64, input logic [7:0] e8, input int s);
        logic [63:0] e;
        logic [7:0]  f;
        chk({tag, "_n64"}, q64.size() - qb64, n);
        chk({tag, "_n8"}, q8.size() - qb8, n);
        for (int i = 0; i < n && qb64 + i < q64.size(); i++) begin
            e = e64 + 64'(s * i);
            chk({tag, "_d64"}, q64[qb64 + i], {4{e}});
        end
        for (int i = 0; i < n && qb8 + i < q8.size(); i++) begin
            f = e8 + 8'(s * i);
            chk({tag, "_d8"}, q8[qb8 + i], {4{f}});
        end
    endtask

    logic [2:0]  t_mode [6] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6};
    logic [63:0] t_a    [6] = '{64'h00, 64'h10, 64'h80, 64'h80, 64'h0F, 64'h33};
    logic [63:0] t_b    [6] = '{64'h01, 64'h10, 64'h7F, 64'h7F, 64'hFF, 64'h55};
    logic [63:0] t_e64  [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h100, 64'h80, 64'h7F, 64'hF0, 64'h33};
    logic [7:0]  t_e8   [6] = '{8'hFF, 8'h00, 8'h7F, 8'h80, 8'hF0, 8'h33};

    initial begin
        n_vec = 0; n_err = 0; fire_cnt = 0; fb = 0; lat_bad = 0; prev_fire = 0;
        rst_i = 1; v0 = 0; v1 = 0; out_rdy = 0; csr_valid = 0;
        csr_set[0] = 0; csr_set[1] = 0; csr_set[2] = 0;
        begin_job(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {o_v64, o_v8}, 0);
        chk("rst_data", {o_d64, o_d8} , 0);
        chk("rst_in_rdy", {r0_64, r1_64, r0_8, r1_8}, 0);
        chk("rst_ro", {ro64[0], ro64[1], ro8[0], ro8[1]}, 0);
        rst_i = 0;
        tick();
        chk("rst_csr_rdy", {cr64, cr8}, 2'b11);

        v0 = 1; v1 = 1; out_rdy = 1;
        begin_job(5, 7, 0);
        csr_write(3'd0, 0, 1);
        repeat (4) tick();
        chk("len0_busy", {ro64[0][0], ro8[0][0]}, 0);
        chk("len0_in_rdy", {r0_64, r1_64, r0_8, r1_8}, 0);
        chk("len0_valid", {o_v64, o_v8}, 0);
        chk("len0_fires", fire_cnt - fb, 0);
        chk("len0_beats", q64.size() - qb64, 0);
        chk("len0_ro1", ro64[1], 0);

        begin_job(5, 7, 0);
        csr_write(3'd0, 3, 1);
        chk("add_busy", {ro64[0][0], ro8[0][0]}, 2'b11);
        chk("add_first_valid", o_v64, 0);
        chk("add_first_fire", {r0_64, r1_64}, 2'b11);
        tick();
        chk("add_lat_valid", o_v64, 1);
        chk("add_lat_data", o_d64, {4{64'd12}});
        wait_idle();
        chk("add_ro1_64", ro64[1], 5);
        chk("add_ro1_8", ro8[1], 5);
        check_beats("add", 3, 64'd12, 8'd12, 0);

        for (int k = 0; k < 6; k++) begin
            begin_job(t_a[k], t_b[k], 0);
            csr_write(t_mode[k], 1, 1);
            wait_idle();
            check_beats($sformatf("alu_m%0d", t_mode[k]), 1, t_e64[k], t_e8[k], 0);
        end

        out_rdy = 0;
        begin_job(10, 20, 1);
        csr_write(3'd0, 8, 1);
        repeat (10) tick();
        chk("bp_fires", fire_cnt - fb, 4);
        chk("bp_in_rdy", {r0_64, r0_8}, 0);
        chk("bp_beats", q64.size() - qb64, 0);
        out_rdy = 1;
        wait_idle();
        check_beats("bp", 8, 64'd30, 8'd30, 2);

        out_rdy = 0;
        begin_job(5, 7, 0);
        csr_write(3'd0, 4, 1);
        csr_set[0] = 1; csr_set[1] = 2; csr_set[2] = 1;
        csr_valid = 1;
        repeat (6) tick();
        chk("busy_csr_rdy", {cr64, cr8}, 0);
        csr_valid = 0;
        out_rdy = 1;
        wait_idle();
        check_beats("busy_csr", 4, 64'd12, 8'd12, 0);

        out_rdy = 0;
        begin_job(64'h0F, 64'hFF, 0);
        csr_write(3'd3, 6, 1);
        repeat (2) tick();
        chk("mid_fires", fire_cnt - fb, 2);
        rst_i = 1;
        #1;
        chk("mid_valid", {o_v64, o_v8}, 0);
        chk("mid_data", {o_d64, o_d8}, 0);
        chk("mid_in_rdy", {r0_64, r0_8}, 0);
        chk("mid_csr_rdy", {cr64, cr8}, 2'b11);
        chk("mid_busy", {ro64[0][0], ro8[0][0]}, 0);
        @(posedge clk);
        #1;
        rst_i = 0;
        out_rdy = 1;
        begin_job(64'h0F, 64'hFF, 0);
        repeat (5) tick();
        chk("mid_no_beats", q64.size() - qb64, 0);
        chk("mid_empty", {o_v64, o_v8}, 0);
        csr_write(3'd3, 2, 1);
        wait_idle();
        check_beats("post_rst", 2, 64'hF0, 8'hF0, 0);

        chk("latency", lat_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
